// File: rtl/fir_pkg.sv
// Shared types and width helpers for the transposed FIR core.
// Commit FSM encoding plus accumulator/rounding width derivations.
package fir_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } commit_state_t;

    function automatic int fir_acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps) + 1;
    endfunction

    function automatic int fir_addr_w(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

    // One guard bit so the rounding offset can never wrap the accumulator.
    function automatic int fir_rnd_w(input int acc_w);
        return acc_w + 1;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational output stage: arithmetic shift with round-half-up, then clip to OUT_W.
// o_sat flags that clipping changed the value.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int ACC_W     = 22,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 0
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [OUT_W-1:0] o_dat,
    output logic                    o_sat
);

    localparam int EXT_W = fir_rnd_w(ACC_W);
    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [EXT_W-1:0] w_ext;
    logic signed [EXT_W-1:0] w_shf;

    assign w_ext = EXT_W'(i_acc);

    generate
        if (OUT_SHIFT > 0) begin : g_rnd
            localparam logic signed [EXT_W-1:0] RND_HALF = {{(EXT_W-1){1'b0}}, 1'b1} << (OUT_SHIFT-1);
            assign w_shf = (w_ext + RND_HALF) >>> OUT_SHIFT;
        end else begin : g_pass
            assign w_shf = w_ext;
        end
    endgenerate

    always_comb begin
        o_sat = 1'b0;
        o_dat = w_shf[OUT_W-1:0];
        if (w_shf > SAT_MAX) begin
            o_sat = 1'b1;
            o_dat = SAT_MAX[OUT_W-1:0];
        end else if (w_shf < SAT_MIN) begin
            o_sat = 1'b1;
            o_dat = SAT_MIN[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/transposed_fir_core.sv
// Transposed-form FIR with double-buffered coefficients and cascade input/output.
// One-cycle latency; commits wait for the first idle (iInVld=0) cycle.
module transposed_fir_core
    import fir_pkg::*;
#(
    parameter int TAPS      = 3,
    parameter int DATA_W    = 3,
    parameter int COEF_W    = 16,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 0,
    localparam int ACC_W    = fir_acc_w(DATA_W, COEF_W, TAPS),
    localparam int ADDR_W   = fir_addr_w(TAPS)
) (
    input  logic                     iClk_12M,
    input  logic                     iRsn,
    input  logic                     iInVld,
    input  logic signed [DATA_W-1:0] iFirIn,
    input  logic signed [ACC_W-1:0]  iCasIn,
    input  logic                     iClear,
    input  logic                     iCoefWe,
    input  logic [ADDR_W-1:0]        iCoefAddr,
    input  logic signed [COEF_W-1:0] iCoefData,
    input  logic                     iCoefCommit,
    output logic signed [OUT_W-1:0]  oFirOut,
    output logic                     oOutVld,
    output logic signed [ACC_W-1:0]  oCasOut,
    output logic                     oSat,
    output logic                     oCommitPend
);

    logic signed [COEF_W-1:0] r_coef   [TAPS];
    logic signed [COEF_W-1:0] r_shadow [TAPS];
    logic signed [ACC_W-1:0]  r_z      [1:TAPS-1];

    logic signed [OUT_W-1:0]  r_fir_out;
    logic signed [ACC_W-1:0]  r_cas_out;
    logic                     r_out_vld;
    logic                     r_sat;
    commit_state_t            r_state;

    commit_state_t            w_state_nxt;
    logic                     w_apply;
    logic                     w_acc;
    logic                     w_addr_ok;
    logic signed [ACC_W-1:0]  w_x_ext;
    logic signed [ACC_W-1:0]  w_prod [TAPS];
    logic signed [ACC_W-1:0]  w_sum  [TAPS];
    logic signed [OUT_W-1:0]  w_rs_dat;
    logic                     w_rs_sat;

    assign w_acc     = iInVld && !iClear;
    assign w_addr_ok = {1'b0, iCoefAddr} < (ADDR_W+1)'(TAPS);
    assign w_x_ext   = ACC_W'(iFirIn);

    // Every tap sums into ACC_W, which has headroom for TAPS full-scale products.
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        logic signed [ACC_W-1:0] w_c_ext;
        assign w_c_ext   = ACC_W'(r_coef[k]);
        assign w_prod[k] = w_c_ext * w_x_ext;
        if (k == TAPS-1) begin : g_last
            assign w_sum[k] = w_prod[k] + iCasIn;
        end else begin : g_mid
            assign w_sum[k] = w_prod[k] + r_z[k+1];
        end
    end

    fir_round_sat #(
        .ACC_W     (ACC_W),
        .OUT_W     (OUT_W),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_round_sat (
        .i_acc (w_sum[0]),
        .o_dat (w_rs_dat),
        .o_sat (w_rs_sat)
    );

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            for (int k = 1; k < TAPS; k++) r_z[k] <= '0;
        end else if (iClear) begin
            for (int k = 1; k < TAPS; k++) r_z[k] <= '0;
        end else if (w_acc) begin
            for (int k = 1; k < TAPS; k++) r_z[k] <= w_sum[k];
        end
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            r_out_vld <= 1'b0;
            r_fir_out <= '0;
            r_cas_out <= '0;
            r_sat     <= 1'b0;
        end else if (iClear) begin
            r_out_vld <= 1'b0;
            r_fir_out <= '0;
            r_cas_out <= '0;
            r_sat     <= 1'b0;
        end else begin
            r_out_vld <= iInVld;
            if (iInVld) begin
                r_fir_out <= w_rs_dat;
                r_cas_out <= w_sum[0];
                r_sat     <= w_rs_sat;
            end
        end
    end

    // The commit copies the pre-edge shadow, so a same-cycle write lands only in shadow.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            for (int k = 0; k < TAPS; k++) begin
                r_coef[k]   <= '0;
                r_shadow[k] <= '0;
            end
        end else begin
            if (w_apply) begin
                for (int k = 0; k < TAPS; k++) r_coef[k] <= r_shadow[k];
            end
            if (iCoefWe && w_addr_ok) begin
                r_shadow[iCoefAddr] <= iCoefData;
            end
        end
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_apply     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (iCoefCommit) w_state_nxt = ST_PEND;
            end
            ST_PEND: begin
                if (!iInVld) begin
                    w_apply     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign oFirOut     = r_fir_out;
    assign oCasOut     = r_cas_out;
    assign oOutVld     = r_out_vld;
    assign oSat        = r_sat;
    assign oCommitPend = (r_state == ST_PEND);

endmodule

// File: tb/tb_transposed_fir_core.sv
// Directed bench for transposed_fir_core at default parameters (TAPS=3, DATA_W=3).
// Inputs change 1 ns after the rising edge; outputs are checked at that same point.
module tb_transposed_fir_core;

    localparam int DATA_W = 3;
    localparam int COEF_W = 16;
    localparam int OUT_W  = 16;
    localparam int ACC_W  = 22;
    localparam int ADDR_W = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_vld;
    logic signed [DATA_W-1:0] fir_in;
    logic signed [ACC_W-1:0]  cas_in;
    logic                     clear;
    logic                     coef_we;
    logic [ADDR_W-1:0]        coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     coef_commit;
    logic signed [OUT_W-1:0]  fir_out;
    logic                     out_vld;
    logic signed [ACC_W-1:0]  cas_out;
    logic                     sat;
    logic                     commit_pend;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    transposed_fir_core dut (
        .iClk_12M    (clk),
        .iRsn        (rst_n),
        .iInVld      (in_vld),
        .iFirIn      (fir_in),
        .iCasIn      (cas_in),
        .iClear      (clear),
        .iCoefWe     (coef_we),
        .iCoefAddr   (coef_addr),
        .iCoefData   (coef_data),
        .iCoefCommit (coef_commit),
        .oFirOut     (fir_out),
        .oOutVld     (out_vld),
        .oCasOut     (cas_out),
        .oSat        (sat),
        .oCommitPend (commit_pend)
    );

    task automatic check(input string tag, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int vld, input longint fir, input longint cas, input int s);
        check({tag, ".vld"}, longint'(out_vld), longint'(vld));
        check({tag, ".fir"}, longint'(fir_out), fir);
        check({tag, ".cas"}, longint'(cas_out), cas);
        check({tag, ".sat"}, longint'(sat), longint'(s));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int x);
        in_vld = 1'b1;
        fir_in = DATA_W'(x);
        step();
        in_vld = 1'b0;
        fir_in = '0;
    endtask

    task automatic wr_coef(input int addr, input int data);
        coef_we   = 1'b1;
        coef_addr = ADDR_W'(addr);
        coef_data = COEF_W'(data);
        step();
        coef_we   = 1'b0;
    endtask

    task automatic commit_idle(input string tag);
        coef_commit = 1'b1;
        step();
        coef_commit = 1'b0;
        check({tag, ".pend_set"}, longint'(commit_pend), 1);
        step();
        check({tag, ".pend_clr"}, longint'(commit_pend), 0);
    endtask

    task automatic load3(input string tag, input int c0, input int c1, input int c2);
        wr_coef(0, c0);
        wr_coef(1, c1);
        wr_coef(2, c2);
        commit_idle(tag);
    endtask

    task automatic impulse(input string tag);
        run(1); chk_out({tag, ".0"}, 1, 1, 1, 0);
        run(0); chk_out({tag, ".1"}, 1, 2, 2, 0);
        run(0); chk_out({tag, ".2"}, 1, 3, 3, 0);
        run(0); chk_out({tag, ".3"}, 1, 0, 0, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_vld      = 1'b0;
        fir_in      = '0;
        cas_in      = '0;
        clear       = 1'b0;
        coef_we     = 1'b0;
        coef_addr   = '0;
        coef_data   = '0;
        coef_commit = 1'b0;

        repeat (3) step();
        chk_out("rst", 0, 0, 0, 0);
        check("rst.pend", longint'(commit_pend), 0);
        #2 rst_n = 1'b1;
        step();

        // Impulse response with coefficients 1,2,3.
        load3("ld123", 1, 2, 3);
        impulse("imp");

        // Every-other-cycle step input: outputs hold between valid cycles.
        run(1); chk_out("gap.s0", 1, 1, 1, 0);
        step(); chk_out("gap.h0", 0, 1, 1, 0);
        run(1); chk_out("gap.s1", 1, 3, 3, 0);
        step(); chk_out("gap.h1", 0, 3, 3, 0);
        run(1); chk_out("gap.s2", 1, 6, 6, 0);
        step(); chk_out("gap.h2", 0, 6, 6, 0);
        run(1); chk_out("gap.s3", 1, 6, 6, 0);

        // Clear with a concurrent sample discards it and empties the delay line.
        clear  = 1'b1;
        in_vld = 1'b1;
        fir_in = DATA_W'(1);
        step();
        clear  = 1'b0;
        in_vld = 1'b0;
        fir_in = '0;
        chk_out("clr", 0, 0, 0, 0);
        impulse("imp_clr");

        run(-4); chk_out("neg.0", 1, -4, -4, 0);
        run(0);  chk_out("neg.1", 1, -8, -8, 0);
        run(0);  chk_out("neg.2", 1, -12, -12, 0);
        run(0);  chk_out("neg.3", 1, 0, 0, 0);

        // Commit requested while streaming is held off until an idle cycle.
        load3("ld100", 1, 0, 0);
        wr_coef(0, 2);
        coef_commit = 1'b1;
        run(1); chk_out("cs.0", 1, 1, 1, 0);
        check("cs.pend0", longint'(commit_pend), 1);
        coef_commit = 1'b0;
        run(1); chk_out("cs.1", 1, 1, 1, 0);
        check("cs.pend1", longint'(commit_pend), 1);
        coef_commit = 1'b1;
        run(1); chk_out("cs.2", 1, 1, 1, 0);
        check("cs.pend2", longint'(commit_pend), 1);
        coef_commit = 1'b0;
        coef_we     = 1'b1;
        coef_addr   = ADDR_W'(0);
        coef_data   = COEF_W'(5);
        step();
        coef_we     = 1'b0;
        chk_out("cs.idle", 0, 1, 1, 0);
        check("cs.pend_apply", longint'(commit_pend), 0);
        run(1); chk_out("cs.new", 1, 2, 2, 0);
        step();
        check("cs.pend_absorb", longint'(commit_pend), 0);
        run(1); chk_out("cs.excl", 1, 2, 2, 0);

        // Cascade input reaches the output TAPS-1 samples after injection.
        wr_coef(0, 0);
        commit_idle("ld000");
        cas_in = ACC_W'(100);
        run(0); chk_out("cas.0", 1, 0, 0, 0);
        cas_in = '0;
        run(0); chk_out("cas.1", 1, 0, 0, 0);
        run(0); chk_out("cas.2", 1, 100, 100, 0);
        run(0); chk_out("cas.3", 1, 0, 0, 0);

        // Saturation: 3*32767 = 98301 per tap.
        load3("ldmax", 32767, 32767, 32767);
        run(3);  chk_out("sat.0", 1, 32767, 98301, 1);
        run(3);  chk_out("sat.1", 1, 32767, 196602, 1);
        run(3);  chk_out("sat.2", 1, 32767, 294903, 1);
        run(0);  chk_out("sat.3", 1, 32767, 196602, 1);
        run(0);  chk_out("sat.4", 1, 32767, 98301, 1);
        run(0);  chk_out("sat.5", 1, 0, 0, 0);
        run(-4); chk_out("sat.neg", 1, -32768, -131068, 1);

        // Asynchronous reset mid-stream with a commit pending.
        coef_commit = 1'b1;
        run(-4);
        coef_commit = 1'b0;
        check("pre_rst.pend", longint'(commit_pend), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_out("arst", 0, 0, 0, 0);
        check("arst.pend", longint'(commit_pend), 0);
        #2 rst_n = 1'b1;
        step();
        run(1); chk_out("post_rst", 1, 0, 0, 0);
        load3("ld123b", 1, 2, 3);
        impulse("imp_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
